// File: rtl/ram_arbiter_pkg.sv
// Shared types for the two-master RAM arbiter: TileLink-style A-channel request,
// opcode constants and the arbiter FSM state encoding.
package ram_arbiter_pkg;

    typedef struct packed {
        logic [2:0]  a_opcode;
        logic [31:0] a_address;
        logic [31:0] a_data;
        logic [3:0]  a_mask;
    } tilelink_a;

    localparam logic [2:0] OpPutFullData = 3'd0;
    localparam logic [2:0] OpGet         = 3'd4;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } arb_state_e;

    // Anything that is not a Get is acknowledged like PutFullData.
    function automatic logic is_get(input tilelink_a req);
        return req.a_opcode == OpGet;
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: a tie goes to the master that was
// not granted last; a lone requester always wins.
module rr_pick2 (
    input  logic [1:0] valids,
    input  logic       last_grant,
    output logic       grant,
    output logic       any
);

    always_comb begin
        any   = |valids;
        grant = 1'b0;
        if (valids == 2'b11) begin
            grant = ~last_grant;
        end else if (valids[1]) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-master arbiter in front of a single-ported RAM with one-cycle read latency.
// One transaction in flight: accept, issue, wait for read data, respond.
module ram_arbiter
    import ram_arbiter_pkg::*;
(
    input  logic        clock,
    input  logic        reset,

    input  logic        m0_a_valid,
    output logic        m0_a_ready,
    input  tilelink_a   m0_tla,
    output logic        m0_d_valid,
    input  logic        m0_d_ready,
    output logic [31:0] m0_d_data,

    input  logic        m1_a_valid,
    output logic        m1_a_ready,
    input  tilelink_a   m1_tla,
    output logic        m1_d_valid,
    input  logic        m1_d_ready,
    output logic [31:0] m1_d_data,

    output logic        ram_a_valid,
    output tilelink_a   ram_tla,
    input  logic [31:0] ram_rdata
);

    arb_state_e  state_q, state_d;
    logic        last_grant_q;
    logic        grant_q;
    tilelink_a   req_q;
    logic [31:0] rdata_q;

    logic        pick_grant;
    logic        pick_any;
    logic        accept;
    logic        resp_ready;

    rr_pick2 u_pick (
        .valids     ({m1_a_valid, m0_a_valid}),
        .last_grant (last_grant_q),
        .grant      (pick_grant),
        .any        (pick_any)
    );

    assign resp_ready = grant_q ? m1_d_ready : m0_d_ready;

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        m0_a_ready  = 1'b0;
        m1_a_ready  = 1'b0;
        m0_d_valid  = 1'b0;
        m1_d_valid  = 1'b0;
        m0_d_data   = '0;
        m1_d_data   = '0;
        ram_a_valid = 1'b0;
        ram_tla     = '0;

        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    accept  = 1'b1;
                    state_d = StIssue;
                    if (pick_grant) begin
                        m1_a_ready = 1'b1;
                    end else begin
                        m0_a_ready = 1'b1;
                    end
                end
            end
            StIssue: begin
                ram_a_valid = 1'b1;
                ram_tla     = req_q;
                state_d     = StWait;
            end
            StWait: begin
                state_d = StResp;
            end
            StResp: begin
                if (grant_q) begin
                    m1_d_valid = 1'b1;
                    m1_d_data  = rdata_q;
                end else begin
                    m0_d_valid = 1'b1;
                    m0_d_data  = rdata_q;
                end
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // last_grant resets to 1 so master 0 wins the first tie.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            req_q        <= '0;
            rdata_q      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                grant_q      <= pick_grant;
                last_grant_q <= pick_grant;
                req_q        <= pick_grant ? m1_tla : m0_tla;
            end
            if (state_q == StWait) begin
                rdata_q <= is_get(req_q) ? ram_rdata : 32'h0;
            end
        end
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameters: none; widths fixed by package types.
REQ-002 clock  input  1  single clock; all state updates on posedge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 m0_a_valid  input  1  master 0 request valid.
REQ-005 m0_a_ready  output  1  master 0 request accepted this cycle.
REQ-006 m0_tla  input  tilelink_a  master 0 request (opcode, address, data, mask).
REQ-007 m0_d_valid  output  1  master 0 response valid.
REQ-008 m0_d_ready  input  1  master 0 response consumed.
REQ-009 m0_d_data  output  32  master 0 read data; 0 for write ack.
REQ-010 m1_a_valid, m1_a_ready, m1_tla, m1_d_valid, m1_d_ready, m1_d_data: same as master 0, for master 1.
REQ-011 ram_a_valid  output  1  RAM access strobe.
REQ-012 ram_tla  output  tilelink_a  request driven to RAM.
REQ-013 ram_rdata  input  32  RAM read data, valid exactly 1 cycle after ram_a_valid.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; encoding in package.
REQ-015 IDLE: if any a_valid, grant one master, assert only its a_ready that cycle, latch its tla and grant id, go ISSUE; else stay.
REQ-016 Arbitration SHALL be round-robin over 2: on tie, grant master not granted last; last_grant updates on each grant.
REQ-017 Single requester SHALL be granted regardless of last_grant.
REQ-018 a_ready SHALL be 0 in every state except IDLE; at most one a_ready high per cycle.
REQ-019 ISSUE: ram_a_valid=1 for exactly one cycle with latched request on ram_tla; go WAIT.
REQ-020 WAIT: capture ram_rdata if opcode=Get (4), else capture 0; go RESP.
REQ-021 RESP: assert granted master's d_valid with captured data; hold data stable until d_ready; on d_valid&&d_ready go IDLE.
REQ-022 Other master's d_valid SHALL be 0 throughout.
REQ-023 ram_tla SHALL be 0 when ram_a_valid=0.
REQ-024 Minimum request-to-response latency: 3 cycles (accept, issue, wait, response in 4th cycle); back-to-back throughput one transaction per 4 cycles with d_ready tied high.
REQ-025 Opcodes other than Get (4) and PutFullData (0) SHALL be handled as PutFullData ack with no RAM write suppression.
REQ-026 A new request arriving in IDLE in the same cycle RESP completes SHALL NOT be accepted until the following cycle.

Reset
REQ-027 Reset SHALL force state=IDLE, last_grant=1 (master 0 wins first tie), captured data=0, all valid/ready outputs=0, ram_tla=0.
REQ-028 Reset mid-transaction SHALL discard it without response; requester reissues.

Structure
REQ-029 Shared package holds tilelink_a (a_opcode 3, a_address 32, a_data 32, a_mask 4), opcode constants, FSM state enum.
REQ-030 One sub-module rr_pick2: combinational 2-way round-robin picker (valids, last_grant -> grant id, any).

Verification
REQ-031 Reset: after deassert all outputs 0, state IDLE.
REQ-032 m0 Get addr 0x10 alone, RAM returns 0xDEADBEEF -> m0_a_ready cycle 0, ram_a_valid cycle 1 with addr 0x10, m0_d_valid cycle 3 data 0xDEADBEEF.
REQ-033 Both valid continuously, d_ready=1 -> grants alternate m0,m1,m0,m1 every 4 cycles.
REQ-034 m1 PutFullData data 0x55 -> ram_tla.a_data=0x55 in ISSUE, m1_d_data=0 ack.
REQ-035 d_ready held 0 for 5 cycles in RESP -> d_valid and data stable, no new a_ready, then IDLE after handshake.
REQ-036 reset pulsed during WAIT -> no d_valid, IDLE next cycle, reissued request served normally.
